// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the requesting units and alu_arbiter.
//   master : requester/consumer side (drives req_valid/a/b/op and rsp_ready)
//   slave  : arbiter side (drives req_ready and rsp_valid/id/data/zero)
// Requester i owns req_a/req_b[8i+7:8i] and req_op[3i+2:3i].
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*8-1:0] req_a;
   logic [NUM_REQ*8-1:0] req_b;
   logic [NUM_REQ*3-1:0] req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_data;
   logic                 rsp_zero;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational 8-bit ALU among
// NUM_REQ requesters. One operation in flight at a time; operands are latched on accept,
// the ALU result is captured one cycle later and returned with the owner's ID.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   bus (slave)     request valid/ready + operands, response valid/ready + id/data/zero
//   alu_input_a_o   latched operand A to the ALU
//   alu_input_b_o   latched operand B to the ALU
//   alu_opcode_o    latched opcode to the ALU (not decoded here)
//   alu_out_i       ALU result
//   zero_i          ALU zero flag
//   ops_count_o     (ALU_ARB_STATS_EN only) saturating count of response handshakes
//
// Build option: define ALU_ARB_STATS_EN to add ops_count_o.
//
// state  | meaning
// S_IDLE | scanning for a requester from ptr_q; req_ready asserted for the winner
// S_EXEC | ALU sees latched operands; result captured into rsp_* at end of cycle
// S_RESP | rsp_valid held until the consumer takes it
module alu_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus,
   output logic [7:0]   alu_input_a_o,
   output logic [7:0]   alu_input_b_o,
   output logic [2:0]   alu_opcode_o,
   input  logic [7:0]   alu_out_i,
   input  logic         zero_i
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]  ops_count_o
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   logic [ID_W-1:0] ptr_q;
   logic [7:0]      a_q;
   logic [7:0]      b_q;
   logic [2:0]      op_q;
   logic [ID_W-1:0] id_q;
   logic            rsp_valid_q;
   logic [ID_W-1:0] rsp_id_q;
   logic [7:0]      rsp_data_q;
   logic            rsp_zero_q;

   logic            win_valid;
   logic [ID_W-1:0] win_id;
   logic [ID_W:0]   scan_idx;
   logic [7:0]      win_a;
   logic [7:0]      win_b;
   logic [2:0]      win_op;
   logic [ID_W-1:0] ptr_d;

   // Scan ptr, ptr+1, ... (mod NUM_REQ); one extra bit keeps ptr+k from overflowing
   // before the wrap subtraction.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!win_valid && bus.req_valid[scan_idx[ID_W-1:0]]) begin
            win_valid = 1'b1;
            win_id    = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      win_a  = '0;
      win_b  = '0;
      win_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            win_a  = bus.req_a[8*i +: 8];
            win_b  = bus.req_b[8*i +: 8];
            win_op = bus.req_op[3*i +: 3];
         end
      end
   end

   assign ptr_d = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;

   // Gated by reset so no grant is ever offered while the block is being reset.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == S_IDLE && win_valid && !reset) begin
         bus.req_ready[win_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_valid) begin
                  a_q     <= win_a;
                  b_q     <= win_b;
                  op_q    <= win_op;
                  id_q    <= win_id;
                  ptr_q   <= ptr_d;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data_q  <= alu_out_i;
               rsp_zero_q  <= zero_i;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_input_a_o = a_q;
   assign alu_input_b_o = b_q;
   assign alu_opcode_o  = op_q;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] ops_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ops_count_q <= '0;
      end else if (state_q == S_RESP && bus.rsp_ready && ops_count_q != 16'hFFFF) begin
         ops_count_q <= ops_count_q + 16'd1;
      end
   end

   assign ops_count_o = ops_count_q;
`endif

endmodule
